// File: rtl/plot_framebuffer.sv
// Pixel-plot responder: 160x120x3 framebuffer with clear sweep,
// pixel read-back and 640x480 VGA scanout at 4x4 pixel scale.
module plot_framebuffer #(
  parameter int XSCREEN = 160,
  parameter int YSCREEN = 120,
  parameter logic [2:0] BG_COLOUR = 3'b000,
  parameter int H_VIS = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_VIS = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       plot,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       clear,
  output logic       busy,
  input  logic       rd_req,
  input  logic [7:0] rd_x,
  input  logic [6:0] rd_y,
  output logic       rd_ready,
  output logic       rd_valid,
  output logic [2:0] rd_colour,
  output logic [7:0] drop_count,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       VGA_CLK
);

  localparam int NPIX = XSCREEN * YSCREEN;
  localparam logic [14:0] LAST_ADDR = 15'(NPIX - 1);
  localparam logic [7:0] XMAX = 8'(XSCREEN);
  localparam logic [6:0] YMAX = 7'(YSCREEN);
  localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] HV = 10'(H_VIS);
  localparam logic [9:0] VV = 10'(V_VIS);

  // y*160 + x as shift-add
  function automatic logic [14:0] pix_addr(logic [7:0] px, logic [6:0] py);
    return {1'b0, py, 7'b0} + {3'b0, py, 5'b0} + {7'b0, px};
  endfunction

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state_q;
  state_t      state_d;
  logic [14:0] clr_cnt;
  logic        in_range;
  logic        plot_ok;
  logic        drop;
  logic        rd_in;
  logic        we_a;
  logic [14:0] addr_a;
  logic [2:0]  data_a;
  logic [14:0] rd_idx;
  logic [2:0]  rd_mem;
  logic        rd_p1;
  logic        rd_oob;

  logic [2:0]  mem [NPIX];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (clear) state_d = CLEAR;
      CLEAR: if (clr_cnt == LAST_ADDR) state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    unique case (state_q)
      IDLE:  busy = 1'b0;
      CLEAR: busy = 1'b1;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)   clr_cnt <= '0;
    else if (busy) clr_cnt <= clr_cnt + 15'd1;
    else           clr_cnt <= '0;
  end

  assign in_range = (x < XMAX) && (y < YMAX);
  assign plot_ok  = plot && !busy && in_range;
  assign drop     = plot && !plot_ok;
  assign rd_ready = rd_req && !busy && !plot;
  assign rd_in    = (rd_x < XMAX) && (rd_y < YMAX);
  assign rd_idx   = rd_in ? pix_addr(rd_x, rd_y) : '0;

  assign we_a   = busy || plot_ok;
  assign addr_a = busy ? clr_cnt : pix_addr(x, y);
  assign data_a = busy ? BG_COLOUR : colour;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) drop_count <= '0;
    else if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
  end

  // Scanout counters; pe halves the 50 MHz clock to the pixel rate
  logic        pe;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        vis0;
  logic        hs0;
  logic        vs0;
  logic [14:0] addr_b;
  logic [2:0]  pix;
  logic        hs1;
  logic        vs1;
  logic        vis1;
  logic [2:0]  col_q;

  // Port A (clear/plot/read-back) and port B (scanout)
  always_ff @(posedge Clock) begin
    if (we_a)          mem[addr_a] <= data_a;
    else if (rd_ready) rd_mem <= mem[rd_idx];
    pix <= mem[addr_b];
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rd_p1     <= 1'b0;
      rd_oob    <= 1'b0;
      rd_valid  <= 1'b0;
      rd_colour <= '0;
    end else begin
      rd_p1    <= rd_ready;
      rd_valid <= rd_p1;
      if (rd_ready) rd_oob <= !rd_in;
      if (rd_p1) rd_colour <= rd_oob ? 3'b000 : rd_mem;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pe     <= 1'b0;
      hcount <= '0;
      vcount <= '0;
    end else begin
      pe <= ~pe;
      if (pe) begin
        if (hcount == H_LAST) begin
          hcount <= '0;
          vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
        end else begin
          hcount <= hcount + 10'd1;
        end
      end
    end
  end

  assign vis0   = (hcount < HV) && (vcount < VV);
  assign hs0    = !((hcount >= HS_BEG) && (hcount < HS_END));
  assign vs0    = !((vcount >= VS_BEG) && (vcount < VS_END));
  assign addr_b = vis0 ? pix_addr(hcount[9:2], vcount[8:2]) : '0;

  // Syncs and blank ride alongside the memory read to stay aligned
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      hs1         <= 1'b1;
      vs1         <= 1'b1;
      vis1        <= 1'b0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      col_q       <= '0;
    end else begin
      hs1         <= hs0;
      vs1         <= vs0;
      vis1        <= vis0;
      VGA_HS      <= hs1;
      VGA_VS      <= vs1;
      VGA_BLANK_N <= vis1;
      col_q       <= vis1 ? pix : 3'b000;
    end
  end

  assign VGA_R      = {8{col_q[2]}};
  assign VGA_G      = {8{col_q[1]}};
  assign VGA_B      = {8{col_q[0]}};
  assign VGA_SYNC_N = 1'b0;
  assign VGA_CLK    = pe;

endmodule

// File: tb/tb_plot_framebuffer.sv
// Scoreboard bench for plot_framebuffer; a short vertical frame
// keeps the VS period measurement within the cycle budget.
module tb_plot_framebuffer;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       plot = 1'b0;
  logic [7:0] x = '0;
  logic [6:0] y = '0;
  logic [2:0] colour = '0;
  logic       clear = 1'b0;
  logic       rd_req = 1'b0;
  logic [7:0] rd_x = '0;
  logic [6:0] rd_y = '0;
  logic       busy;
  logic       rd_ready;
  logic       rd_valid;
  logic [2:0] rd_colour;
  logic [7:0] drop_count;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;
  logic       VGA_SYNC_N;
  logic       VGA_CLK;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0] c;
    int         due;
  } exp_t;

  exp_t sb[$];

  plot_framebuffer #(
    .V_VIS(8), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .Clock(Clock), .Resetn(Resetn),
    .plot(plot), .x(x), .y(y), .colour(colour),
    .clear(clear), .busy(busy),
    .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y),
    .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_colour(rd_colour), .drop_count(drop_count),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
    .VGA_CLK(VGA_CLK)
  );

  always #10 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock) begin : mon
    exp_t e;
    if (rd_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected: got colour=%0d want no rd_valid",
                 rd_colour);
      end else begin
        e = sb.pop_front();
        if (rd_colour !== e.c || cyc != e.due) begin
          bad++;
          $display("FAIL rd_colour: got %0d at cyc %0d want %0d at cyc %0d",
                   rd_colour, cyc, e.c, e.due);
        end
      end
    end
  end

  task automatic chk(string nm, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic do_plot(int px, int py, int c);
    plot = 1'b1;
    x = 8'(px);
    y = 7'(py);
    colour = 3'(c);
    tick;
    plot = 1'b0;
  endtask

  task automatic do_read(int px, int py, int c);
    rd_req = 1'b1;
    rd_x = 8'(px);
    rd_y = 7'(py);
    #1;
    chk("rd_ready", int'(rd_ready), 1);
    if (rd_ready) sb.push_back('{3'(c), cyc + 2});
    tick;
    rd_req = 1'b0;
    repeat (3) tick;
  endtask

  function automatic logic sig(int s);
    case (s)
      0:       return VGA_HS;
      1:       return VGA_VS;
      default: return VGA_BLANK_N;
    endcase
  endfunction

  task automatic wait_lvl(int s, logic lvl, output int n);
    n = 0;
    while (sig(s) !== lvl && n < 60000) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 60000) chk("edge_timeout", s, -1);
  endtask

  initial begin
    int n;
    int m;

    repeat (2) @(posedge Clock);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_drop", int'(drop_count), 0);
    chk("rst_hs", int'(VGA_HS), 1);
    chk("rst_vs", int'(VGA_VS), 1);
    chk("rst_blank", int'(VGA_BLANK_N), 0);
    chk("rst_rgb", int'({VGA_R, VGA_G, VGA_B}), 0);
    chk("rst_vgaclk", int'(VGA_CLK), 0);
    Resetn = 1'b1;
    tick;

    do_plot(39, 59, 2);
    do_read(39, 59, 2);

    clear = 1'b1;
    tick;
    clear = 1'b0;
    chk("busy_start", int'(busy), 1);
    n = 0;
    while (busy && n < 25000) begin
      n++;
      if (n == 19000) begin
        plot = 1'b1;
        x = 8'd2;
        y = 7'd2;
        colour = 3'd5;
      end
      tick;
      plot = 1'b0;
    end
    chk("busy_len", n, 19200);
    chk("drop_busy", int'(drop_count), 1);
    do_read(159, 119, 0);
    do_read(2, 2, 0);
    do_read(39, 59, 0);

    do_plot(160, 10, 7);
    do_plot(5, 120, 7);
    chk("drop_oob", int'(drop_count), 3);
    do_read(0, 11, 0);
    do_plot(159, 119, 4);
    chk("drop_edge", int'(drop_count), 3);
    do_read(159, 119, 4);
    for (int i = 0; i < 300; i++) do_plot(255, 127, 1);
    chk("drop_sat", int'(drop_count), 255);

    plot = 1'b1;
    x = 8'd1;
    y = 7'd1;
    colour = 3'd3;
    rd_req = 1'b1;
    rd_x = 8'd1;
    rd_y = 7'd1;
    #1;
    chk("rd_blocked", int'(rd_ready), 0);
    tick;
    plot = 1'b0;
    #1;
    chk("rd_held", int'(rd_ready), 1);
    if (rd_ready) sb.push_back('{3'd3, cyc + 2});
    tick;
    rd_req = 1'b0;
    repeat (3) tick;

    do_plot(0, 0, 7);
    @(negedge Clock);
    wait_lvl(0, 1'b1, n);
    wait_lvl(0, 1'b0, n);
    wait_lvl(0, 1'b1, n);
    chk("hs_low", n, 192);
    wait_lvl(0, 1'b0, m);
    chk("hs_period", n + m, 1600);
    wait_lvl(1, 1'b1, n);
    wait_lvl(1, 1'b0, n);
    wait_lvl(1, 1'b1, n);
    chk("vs_low", n, 3200);
    wait_lvl(1, 1'b0, m);
    chk("vs_period", n + m, 19200);
    wait_lvl(1, 1'b1, n);
    for (int l = 0; l < 4; l++) begin
      wait_lvl(2, 1'b1, n);
      for (int k = 0; k < 8; k++) begin
        chk("rgb_on", int'({VGA_R, VGA_G, VGA_B}), 24'hFFFFFF);
        @(negedge Clock);
      end
      chk("rgb_off", int'({VGA_R, VGA_G, VGA_B}), 0);
      wait_lvl(2, 1'b0, n);
    end
    wait_lvl(2, 1'b1, n);
    chk("rgb_row1", int'({VGA_R, VGA_G, VGA_B}), 0);
    tick;

    do_plot(20, 3, 5);
    do_plot(40, 31, 6);
    do_read(20, 3, 5);
    do_read(40, 31, 6);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    repeat (999) tick;
    chk("busy_mid", int'(busy), 1);
    Resetn = 1'b0;
    #1;
    chk("busy_abort", int'(busy), 0);
    chk("drop_rst", int'(drop_count), 0);
    #5;
    Resetn = 1'b1;
    tick;
    tick;
    do_read(20, 3, 0);
    do_read(40, 31, 6);

    repeat (5) tick;
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
